// File: rtl/memory_access.sv
// memory_access: pipeline memory stage; one data-bus transaction per load/store,
// load alignment/extension, and a registered one-cycle result pulse to writeback.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        execute_valid,
    input  logic [63:0] reg_execute_ALU_data_out,
    input  logic [63:0] reg_execute_csr_data_out,
    input  logic [63:0] reg_execute_rs2_data,
    input  logic [63:0] reg_execute_pc,
    input  logic [31:0] reg_execute_ins,
    input  logic [4:0]  reg_execute_rd,
    input  logic        reg_execute_reg_w,
    input  logic        reg_execute_mem_r,
    input  logic        reg_execute_mem_w,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        memory_busy,
    output logic        memory_valid,
    output logic [63:0] reg_memory_ALU_data_out,
    output logic [63:0] reg_memory_csr_data_out,
    output logic [63:0] reg_memory_data_out,
    output logic [63:0] reg_memory_pc,
    output logic [31:0] reg_memory_ins,
    output logic [4:0]  reg_memory_rd,
    output logic        reg_memory_reg_w,
    output logic        reg_memory_mem_r
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [63:0] r_rs2;
    logic        r_mem_w;
    logic        w_wait;
    logic        w_accept;
    logic        w_mem;
    logic        w_done;
    logic        w_store;
    logic [2:0]  w_off;
    logic [2:0]  w_f3;
    logic [7:0]  w_mask;
    logic [63:0] w_word;
    logic [63:0] w_load;

    assign w_wait   = r_state == WAIT;
    assign w_accept = !w_wait && execute_valid;
    assign w_mem    = reg_execute_mem_r || reg_execute_mem_w;
    assign w_done   = w_wait && dresp_data_ok;
    assign w_store  = w_wait && r_mem_w;
    // The captured ALU result is the effective address while a request is outstanding.
    assign w_off    = reg_memory_ALU_data_out[2:0];
    assign w_f3     = reg_memory_ins[14:12];
    assign w_word   = dresp_data >> {w_off, 3'b000};

    always_comb begin
        w_mask = w_f3[1:0] == 2'd0 ? 8'h01 :
                 w_f3[1:0] == 2'd1 ? 8'h03 :
                 w_f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
        w_load = w_f3 == 3'b000 ? {{56{w_word[7]}}, w_word[7:0]} :
                 w_f3 == 3'b001 ? {{48{w_word[15]}}, w_word[15:0]} :
                 w_f3 == 3'b010 ? {{32{w_word[31]}}, w_word[31:0]} :
                 w_f3 == 3'b100 ? {56'd0, w_word[7:0]} :
                 w_f3 == 3'b101 ? {48'd0, w_word[15:0]} :
                 w_f3 == 3'b110 ? {32'd0, w_word[31:0]} : w_word;
    end

    assign dreq_valid  = w_wait;
    assign memory_busy = w_wait;
    assign dreq_addr   = w_wait ? reg_memory_ALU_data_out : 64'd0;
    assign dreq_size   = w_wait ? {1'b0, w_f3[1:0]} : 3'd0;
    assign dreq_strobe = w_store ? w_mask << w_off : 8'd0;
    assign dreq_data   = w_store ? r_rs2 << {w_off, 3'b000} : 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                 <= IDLE;
            r_rs2                   <= '0;
            r_mem_w                 <= 1'b0;
            memory_valid            <= 1'b0;
            reg_memory_ALU_data_out <= '0;
            reg_memory_csr_data_out <= '0;
            reg_memory_data_out     <= '0;
            reg_memory_pc           <= '0;
            reg_memory_ins          <= '0;
            reg_memory_rd           <= '0;
            reg_memory_reg_w        <= 1'b0;
            reg_memory_mem_r        <= 1'b0;
        end else begin
            memory_valid <= (w_accept && !w_mem) || w_done;
            if (w_accept) begin
                r_state                 <= w_mem ? WAIT : IDLE;
                r_rs2                   <= reg_execute_rs2_data;
                r_mem_w                 <= reg_execute_mem_w;
                reg_memory_ALU_data_out <= reg_execute_ALU_data_out;
                reg_memory_csr_data_out <= reg_execute_csr_data_out;
                reg_memory_data_out     <= '0;
                reg_memory_pc           <= reg_execute_pc;
                reg_memory_ins          <= reg_execute_ins;
                reg_memory_rd           <= reg_execute_rd;
                reg_memory_reg_w        <= reg_execute_reg_w;
                reg_memory_mem_r        <= reg_execute_mem_r;
            end else if (w_done) begin
                r_state             <= IDLE;
                reg_memory_data_out <= r_mem_w ? 64'd0 : w_load;
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: table-driven vectors with a result scoreboard for memory_access,
// plus hand-written back-to-back, WAIT-drop and reset-abort sequences.
module tb_memory_access;
    typedef struct {
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] resp;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        int          lat;
        logic [63:0] exp_data;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] data;
        logic [63:0] pc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        execute_valid = 1'b0;
    logic [63:0] reg_execute_ALU_data_out = '0;
    logic [63:0] reg_execute_csr_data_out = '0;
    logic [63:0] reg_execute_rs2_data = '0;
    logic [63:0] reg_execute_pc = '0;
    logic [31:0] reg_execute_ins = '0;
    logic [4:0]  reg_execute_rd = '0;
    logic        reg_execute_reg_w = 1'b0;
    logic        reg_execute_mem_r = 1'b0;
    logic        reg_execute_mem_w = 1'b0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        memory_busy;
    logic        memory_valid;
    logic [63:0] reg_memory_ALU_data_out;
    logic [63:0] reg_memory_csr_data_out;
    logic [63:0] reg_memory_data_out;
    logic [63:0] reg_memory_pc;
    logic [31:0] reg_memory_ins;
    logic [4:0]  reg_memory_rd;
    logic        reg_memory_reg_w;
    logic        reg_memory_mem_r;

    int   checks = 0;
    int   errors = 0;
    vec_t vec[12];
    sb_t  sb[$];
    sb_t  mon_e;

    memory_access dut (
        .clk(clk), .rst(rst), .execute_valid(execute_valid),
        .reg_execute_ALU_data_out(reg_execute_ALU_data_out),
        .reg_execute_csr_data_out(reg_execute_csr_data_out),
        .reg_execute_rs2_data(reg_execute_rs2_data),
        .reg_execute_pc(reg_execute_pc), .reg_execute_ins(reg_execute_ins),
        .reg_execute_rd(reg_execute_rd), .reg_execute_reg_w(reg_execute_reg_w),
        .reg_execute_mem_r(reg_execute_mem_r), .reg_execute_mem_w(reg_execute_mem_w),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .memory_busy(memory_busy), .memory_valid(memory_valid),
        .reg_memory_ALU_data_out(reg_memory_ALU_data_out),
        .reg_memory_csr_data_out(reg_memory_csr_data_out),
        .reg_memory_data_out(reg_memory_data_out), .reg_memory_pc(reg_memory_pc),
        .reg_memory_ins(reg_memory_ins), .reg_memory_rd(reg_memory_rd),
        .reg_memory_reg_w(reg_memory_reg_w), .reg_memory_mem_r(reg_memory_mem_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every memory_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && memory_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_valid: memory_valid=1 with no expected result (rd=%0d)", reg_memory_rd);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rd", {59'd0, reg_memory_rd}, {59'd0, mon_e.rd});
                chk("sb_alu", reg_memory_ALU_data_out, mon_e.alu);
                chk("sb_data", reg_memory_data_out, mon_e.data);
                chk("sb_pc", reg_memory_pc, mon_e.pc);
            end
        end
    end

    task automatic drive(input vec_t v, input logic [63:0] pc);
        reg_execute_ALU_data_out = v.alu;
        reg_execute_csr_data_out = v.alu ^ 64'h5555;
        reg_execute_rs2_data     = v.rs2;
        reg_execute_pc           = pc;
        reg_execute_ins          = {17'd0, v.f3, 12'h003};
        reg_execute_rd           = v.rd;
        reg_execute_reg_w        = !v.mw;
        reg_execute_mem_r        = v.mr;
        reg_execute_mem_w        = v.mw;
    endtask

    task automatic do_op(input vec_t v, input logic [63:0] pc);
        @(negedge clk);
        drive(v, pc);
        execute_valid = 1'b1;
        sb.push_back('{rd: v.rd, alu: v.alu, data: v.exp_data, pc: pc});
        @(negedge clk);
        execute_valid = 1'b0;
        if (v.mr || v.mw) begin
            chk("dreq_valid", {63'd0, dreq_valid}, 64'd1);
            chk("busy", {63'd0, memory_busy}, 64'd1);
            chk("dreq_addr", dreq_addr, v.alu);
            chk("dreq_size", {61'd0, dreq_size}, {61'd0, 1'b0, v.f3[1:0]});
            chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, v.exp_strobe});
            if (v.mw) chk("dreq_data", dreq_data, v.exp_wdata);
            repeat (v.lat) begin
                @(negedge clk);
                chk("dreq_held", {63'd0, dreq_valid}, 64'd1);
                chk("dreq_addr_held", dreq_addr, v.alu);
                chk("mv_early", {63'd0, memory_valid}, 64'd0);
            end
            dresp_data    = v.resp;
            dresp_data_ok = 1'b1;
            @(negedge clk);
            dresp_data_ok = 1'b0;
            dresp_data    = '0;
            chk("mv_after_ok", {63'd0, memory_valid}, 64'd1);
            chk("dreq_drop", {63'd0, dreq_valid}, 64'd0);
            chk("busy_drop", {63'd0, memory_busy}, 64'd0);
        end else begin
            chk("mv_nonmem", {63'd0, memory_valid}, 64'd1);
            chk("dreq_idle", {63'd0, dreq_valid}, 64'd0);
        end
        @(negedge clk);
        chk("mv_width", {63'd0, memory_valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //          alu                    rs2                     resp                   f3    rd  mr mw lat exp_data                strobe wdata
        vec[0]  = '{64'h1234,              64'h0,                  64'h0,                 3'd0, 5, 0, 0, 0, 64'h0,                  8'h00, 64'h0};
        vec[1]  = '{64'h1003,              64'h0,                  64'h00000000_80000000, 3'd0, 6, 1, 0, 3, 64'hFFFFFFFF_FFFFFF80, 8'h00, 64'h0};
        vec[2]  = '{64'h2004,              64'h0,                  64'h89ABCDEF_00000000, 3'd6, 7, 1, 0, 1, 64'h00000000_89ABCDEF, 8'h00, 64'h0};
        vec[3]  = '{64'h3006,              64'hBEEF,               64'hFFFFFFFF_FFFFFFFF, 3'd1, 0, 0, 1, 0, 64'h0,                  8'hC0, 64'hBEEF0000_00000000};
        vec[4]  = '{64'h4000,              64'h0,                  64'h01234567_89ABCDEF, 3'd3, 8, 1, 0, 2, 64'h01234567_89ABCDEF, 8'h00, 64'h0};
        vec[5]  = '{64'h5002,              64'h0,                  64'h00000000_F00D0000, 3'd1, 9, 1, 0, 0, 64'hFFFFFFFF_FFFFF00D, 8'h00, 64'h0};
        vec[6]  = '{64'h5002,              64'h0,                  64'h00000000_F00D0000, 3'd5, 10, 1, 0, 1, 64'h00000000_0000F00D, 8'h00, 64'h0};
        vec[7]  = '{64'h6004,              64'h0,                  64'h80000001_00000000, 3'd2, 11, 1, 0, 0, 64'hFFFFFFFF_80000001, 8'h00, 64'h0};
        vec[8]  = '{64'h7007,              64'h0,                  64'hAB000000_00000000, 3'd4, 12, 1, 0, 2, 64'h00000000_000000AB, 8'h00, 64'h0};
        vec[9]  = '{64'h8005,              64'h12_345677AA,        64'hFFFFFFFF_FFFFFFFF, 3'd0, 0, 0, 1, 1, 64'h0,                  8'h20, 64'h5677AA00_00000000};
        vec[10] = '{64'h9004,              64'hDEADBEEF,           64'hFFFFFFFF_FFFFFFFF, 3'd2, 0, 0, 1, 0, 64'h0,                  8'hF0, 64'hDEADBEEF_00000000};
        vec[11] = '{64'hA000,              64'h11223344_55667788,  64'hFFFFFFFF_FFFFFFFF, 3'd3, 0, 0, 1, 2, 64'h0,                  8'hFF, 64'h11223344_55667788};

        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, memory_valid}, 64'd0);
        chk("rst_dreq", {63'd0, dreq_valid}, 64'd0);
        chk("rst_busy", {63'd0, memory_busy}, 64'd0);
        chk("rst_data", reg_memory_data_out, 64'd0);
        chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_op(vec[i], 64'h100 + 64'(i) * 4);

        // Three consecutive non-memory pulses.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            v = vec[0];
            v.rd = 5'(20 + i);
            v.alu = 64'h7000 + 64'(i);
            drive(v, 64'h200 + 64'(i) * 4);
            execute_valid = 1'b1;
            sb.push_back('{rd: v.rd, alu: v.alu, data: 64'd0, pc: 64'h200 + 64'(i) * 4});
            @(negedge clk);
            if (i > 0) chk("b2b_valid", {63'd0, memory_valid}, 64'd1);
        end
        execute_valid = 1'b0;
        chk("b2b_valid_last", {63'd0, memory_valid}, 64'd1);
        @(negedge clk);
        chk("b2b_end", {63'd0, memory_valid}, 64'd0);

        // execute_valid during WAIT must be ignored.
        v = vec[4];
        @(negedge clk);
        drive(v, 64'h300);
        execute_valid = 1'b1;
        sb.push_back('{rd: v.rd, alu: v.alu, data: v.exp_data, pc: 64'h300});
        @(negedge clk);
        v = vec[0];
        v.rd = 5'd31;
        drive(v, 64'h304);
        @(negedge clk);
        execute_valid = 1'b0;
        chk("wait_ignore_dreq", {63'd0, dreq_valid}, 64'd1);
        chk("wait_ignore_addr", dreq_addr, 64'h4000);
        dresp_data    = vec[4].resp;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("wait_ignore_mv", {63'd0, memory_valid}, 64'd1);
        @(negedge clk);
        chk("wait_ignore_rd", {59'd0, reg_memory_rd}, 64'd8);

        // Reset while WAIT aborts the access with no result pulse.
        v = vec[1];
        @(negedge clk);
        drive(v, 64'h400);
        execute_valid = 1'b1;
        @(negedge clk);
        execute_valid = 1'b0;
        chk("abort_pre_dreq", {63'd0, dreq_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_dreq", {63'd0, dreq_valid}, 64'd0);
        chk("abort_busy", {63'd0, memory_busy}, 64'd0);
        chk("abort_valid", {63'd0, memory_valid}, 64'd0);
        chk("abort_rd", {59'd0, reg_memory_rd}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dresp_data    = vec[1].resp;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("abort_no_mv", {63'd0, memory_valid}, 64'd0);
        @(negedge clk);
        chk("abort_no_mv2", {63'd0, memory_valid}, 64'd0);
        chk("abort_idle", {63'd0, dreq_valid}, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
